// File: rtl/key_tone_gen.sv
// Keyboard tone generator: the most recently pressed key selects a note, which is
// played as a square wave, followed by a fixed-length tail once every key is released.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | silent, amplifier off, phase and release counters held at 0
//   ST_PLAY    | tone sounding while at least one key is held
//   ST_RELEASE | all keys up, tone continues for RELEASE_CYCLES cycles
module key_tone_gen #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int RELEASE_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] alpha_table,
    input  logic [20:0] updated_table,
    output logic        audio_pwm,
    output logic        audio_sd,
    output logic        playing,
    output logic [4:0]  note_idx
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    function automatic int base_hz(input int idx);
        case (idx % 7)
            0:       return 262;
            1:       return 294;
            2:       return 330;
            3:       return 349;
            4:       return 392;
            5:       return 440;
            default: return 494;
        endcase
    endfunction

    // Bit groups are top row (C6 octave), home row (C5), bottom row (C4).
    function automatic int octave_mult(input int idx);
        if (idx >= 14)
            return 1;
        else if (idx >= 7)
            return 2;
        else
            return 4;
    endfunction

    logic [19:0] half_tab [21];

    for (genvar g = 0; g < 21; g++) begin : g_half
        localparam int HALF_G = CLK_HZ / (2 * base_hz(g) * octave_mult(g));
        if (HALF_G < 1 || HALF_G >= (1 << 20)) begin : g_range
            $error("key_tone_gen: half-period out of 20-bit range");
        end
        assign half_tab[g] = 20'(HALF_G);
    end

    logic [1:0]       state_q, state_d;
    logic [4:0]       note_q, note_d;
    logic [19:0]      phase_q, phase_d;
    logic [REL_W-1:0] rel_q, rel_d;
    logic             pwm_q, pwm_d;
    logic             sd_q, playing_q, active_d;
    logic [20:0]      prev_q;

    logic             event_w;
    logic [4:0]       new_note;
    logic [19:0]      half_cur;

    assign event_w  = (updated_table != prev_q) && (|updated_table);
    assign half_cur = half_tab[note_q];

    always_comb begin
        new_note = 5'd0;
        for (int i = 20; i >= 0; i--) begin
            if (updated_table[i])
                new_note = 5'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        phase_d = phase_q;
        rel_d   = rel_q;
        pwm_d   = pwm_q;
        case (state_q)
            ST_PLAY, ST_RELEASE: begin
                if (phase_q == half_cur - 20'd1) begin
                    phase_d = 20'd0;
                    pwm_d   = ~pwm_q;
                end else begin
                    phase_d = phase_q + 20'd1;
                end
                // A fresh key press outranks both the release check and the tail timer.
                if (event_w) begin
                    state_d = ST_PLAY;
                    note_d  = new_note;
                    phase_d = 20'd0;
                    pwm_d   = 1'b0;
                    rel_d   = '0;
                end else if (state_q == ST_PLAY) begin
                    if (alpha_table == 21'd0) begin
                        state_d = ST_RELEASE;
                        rel_d   = '0;
                    end
                end else if (rel_q == REL_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = 20'd0;
                    pwm_d   = 1'b0;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 20'd0;
                rel_d   = '0;
                pwm_d   = 1'b0;
                if (event_w) begin
                    state_d = ST_PLAY;
                    note_d  = new_note;
                end
            end
        endcase
    end

    assign active_d = (state_d != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            note_q    <= 5'd0;
            phase_q   <= 20'd0;
            rel_q     <= '0;
            pwm_q     <= 1'b0;
            sd_q      <= 1'b0;
            playing_q <= 1'b0;
            prev_q    <= 21'd0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            phase_q   <= phase_d;
            rel_q     <= rel_d;
            pwm_q     <= pwm_d;
            sd_q      <= active_d;
            playing_q <= active_d;
            prev_q    <= updated_table;
        end
    end

    assign audio_pwm = pwm_q;
    assign audio_sd  = sd_q;
    assign playing   = playing_q;
    assign note_idx  = note_q;

endmodule

// File: tb/tb_key_tone_gen.sv
// Bench for key_tone_gen: directed key sequences, an arithmetic reference model
// compared every cycle, and hand-computed spot values.
module tb_key_tone_gen;

    localparam int CLK_HZ  = 8800;
    localparam int REL_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [20:0] alpha = '0;
    logic [20:0] upd = '0;
    logic        audio_pwm, audio_sd, playing;
    logic [4:0]  note_idx;

    int checks = 0;
    int failures = 0;

    key_tone_gen #(.CLK_HZ(CLK_HZ), .RELEASE_CYCLES(REL_CYC)) dut (
        .clk(clk),
        .rst(rst),
        .alpha_table(alpha),
        .updated_table(upd),
        .audio_pwm(audio_pwm),
        .audio_sd(audio_sd),
        .playing(playing),
        .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int half_of(input int idx);
        int base [7];
        int mult;
        base = '{262, 294, 330, 349, 392, 440, 494};
        mult = (idx >= 14) ? 1 : ((idx >= 7) ? 2 : 4);
        return CLK_HZ / (2 * base[idx % 7] * mult);
    endfunction

    function automatic int lowest(input logic [20:0] v);
        for (int i = 0; i < 21; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Reference model: k counts edges since the note started, r edges since release began.
    bit          m_active = 0;
    bit          m_rel = 0;
    bit          m_ev;
    int          m_note = 0;
    int          m_k = 0;
    int          m_r = 0;
    logic [20:0] m_prev = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_rel = 0; m_note = 0; m_k = 0; m_r = 0; m_prev = '0;
        end else begin
            m_ev   = (upd != m_prev) && (upd != 0);
            m_prev = upd;
            if (m_ev) begin
                m_active = 1; m_rel = 0; m_note = lowest(upd); m_k = 0;
            end else if (m_active) begin
                m_k++;
                if (m_rel) begin
                    m_r++;
                    if (m_r == REL_CYC) begin
                        m_active = 0; m_rel = 0;
                    end
                end else if (alpha == 0) begin
                    m_rel = 1; m_r = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("cmp_playing", playing, m_active);
        chk("cmp_sd", audio_sd, m_active);
        chk("cmp_note", note_idx, m_note);
        chk("cmp_pwm", audio_pwm, m_active ? ((m_k / half_of(m_note)) % 2) : 0);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        chk("model_half_c4", half_of(14), 16);
        chk("model_half_a4", half_of(19), 10);
        chk("model_half_a5", half_of(12), 5);
        chk("model_half_c6", half_of(0), 4);

        // Reset with random inputs
        #3 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            alpha = 21'($urandom);
            upd   = 21'($urandom);
        end
        edges(1);
        chk("rst_pwm", audio_pwm, 0);
        chk("rst_sd", audio_sd, 0);
        chk("rst_playing", playing, 0);
        chk("rst_note", note_idx, 0);
        @(negedge clk);
        alpha = '0; upd = '0; rst = 1'b0;
        edges(3);
        chk("idle_playing", playing, 0);

        // Press N (A4)
        @(negedge clk);
        alpha = 21'(1) << 19; upd = 21'(1) << 19;
        edges(1);
        chk("pressN_playing", playing, 1);
        chk("pressN_note", note_idx, 19);
        chk("pressN_sd", audio_sd, 1);
        chk("pressN_pwm0", audio_pwm, 0);
        edges(9);
        chk("pressN_pwm9", audio_pwm, 0);
        edges(1);
        chk("pressN_pwm10", audio_pwm, 1);
        edges(10);
        chk("pressN_pwm20", audio_pwm, 0);

        // Sticky input, then retrigger to A5 mid-high
        edges(175);
        chk("sticky_pwm195", audio_pwm, 1);
        chk("sticky_note", note_idx, 19);
        @(negedge clk);
        alpha = 21'(1) << 12; upd = 21'(1) << 12;
        edges(1);
        chk("retrig_note", note_idx, 12);
        chk("retrig_pwm0", audio_pwm, 0);
        edges(4);
        chk("retrig_pwm4", audio_pwm, 0);
        edges(1);
        chk("retrig_pwm5", audio_pwm, 1);
        edges(5);
        chk("retrig_pwm10", audio_pwm, 0);

        // Release tail
        edges(20);
        @(negedge clk);
        alpha = '0; upd = '0;
        edges(1);
        chk("rel_start_playing", playing, 1);
        edges(15);
        chk("rel_15_playing", playing, 1);
        chk("rel_15_pwm", audio_pwm, 1);
        edges(1);
        chk("rel_end_playing", playing, 0);
        chk("rel_end_sd", audio_sd, 0);
        chk("rel_end_pwm", audio_pwm, 0);
        chk("rel_end_note_kept", note_idx, 12);

        // Multi-key: lowest index wins
        edges(3);
        @(negedge clk);
        alpha = (21'(1) << 14) | (21'(1) << 19);
        upd   = (21'(1) << 14) | (21'(1) << 19);
        edges(1);
        chk("multi_note", note_idx, 14);
        edges(15);
        chk("multi_pwm15", audio_pwm, 0);
        edges(1);
        chk("multi_pwm16", audio_pwm, 1);
        edges(4);

        // Asynchronous reset mid-play
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_pwm", audio_pwm, 0);
        chk("async_rst_sd", audio_sd, 0);
        chk("async_rst_playing", playing, 0);
        chk("async_rst_note", note_idx, 0);
        edges(2);
        @(negedge clk);
        rst = 1'b0;
        edges(1);
        chk("post_rst_event_playing", playing, 1);
        chk("post_rst_event_note", note_idx, 14);
        edges(5);

        // Event outranks all-keys-up in the same cycle
        @(negedge clk);
        alpha = '0; upd = 21'(1);
        edges(1);
        chk("prio_playing", playing, 1);
        chk("prio_note", note_idx, 0);
        edges(1);
        chk("prio_then_release_playing", playing, 1);
        edges(20);
        chk("prio_final_idle", playing, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
